// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with mid-bit majority vote
//   i_sys_clk      system clock
//   i_sys_rst      synchronous active-high reset
//   i_rx           asynchronous serial input, idle high
//   i_rx_uart_bps  baud select (0:2400 .. 6:115200, 7:9600)
//   i_rx_uart_clk  0: 26 MHz system clock, 1: 50 MHz system clock
//   o_data         last good byte, held until the next good byte
//   o_flag         one-cycle strobe, o_data updated
//   o_frame_err    one-cycle strobe, stop bit sampled low
//   o_busy         high from start detection until back in IDLE
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_rx,
    input  logic [2:0] i_rx_uart_bps,
    input  logic       i_rx_uart_clk,
    output logic [7:0] o_data,
    output logic       o_flag,
    output logic       o_frame_err,
    output logic       o_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_e;
    localparam logic [14:0] D26 [0:7] = '{15'd10833, 15'd5416, 15'd2708, 15'd1354,
                                          15'd677, 15'd451, 15'd225, 15'd2708};
    localparam logic [14:0] D50 [0:7] = '{15'd20833, 15'd10416, 15'd5208, 15'd2604,
                                          15'd1302, 15'd868, 15'd434, 15'd5208};
    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic [14:0]            cnt_q, cnt_d;
    logic [14:0]            d_q, d_d;
    logic [14:0]            h_q, h_d;
    logic [3:0]             bit_q, bit_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [1:0]             smp_q, smp_d;
    logic [7:0]             data_q, data_d;
    logic                   flag_q, flag_d;
    logic                   ferr_q, ferr_d;
    logic                   rx_s;
    logic                   wrap;
    logic                   at_dec;
    logic                   vote;
    logic [14:0]            d_sel;
    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign d_sel  = i_rx_uart_clk ? D50[i_rx_uart_bps] : D26[i_rx_uart_bps];
    assign wrap   = cnt_q == d_q - 15'd1;
    assign at_dec = cnt_q == h_q + 15'd1;
    // samples at H-1 and H are held; the H+1 sample is the live line
    assign vote   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        h_d     = h_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        smp_d   = smp_q;
        data_d  = data_q;
        flag_d  = 1'b0;
        ferr_d  = 1'b0;
        if (state_q == START || state_q == DATA || state_q == STOP) begin
            cnt_d = wrap ? 15'd0 : cnt_q + 15'd1;
            smp_d[0] = (cnt_q == h_q - 15'd1) ? rx_s : smp_q[0];
            smp_d[1] = (cnt_q == h_q) ? rx_s : smp_q[1];
        end
        case (state_q)
            IDLE: begin
                // bit timing is frozen here so config changes only affect later frames
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = 15'd0;
                    bit_d   = 4'd0;
                    d_d     = d_sel;
                    h_d     = d_sel >> 1;
                end
            end
            START: begin
                if (at_dec && vote) state_d = IDLE;
                else if (wrap) begin
                    state_d = DATA;
                    bit_d   = 4'd1;
                end
            end
            DATA: begin
                if (at_dec) shreg_d = {vote, shreg_q[7:1]};
                if (wrap) begin
                    bit_d   = bit_q + 4'd1;
                    state_d = (bit_q == 4'd8) ? STOP : DATA;
                end
            end
            STOP: begin
                // leave at the stop-bit centre so a back-to-back start edge is not missed
                if (at_dec) begin
                    state_d = vote ? IDLE : WAIT_HI;
                    data_d  = vote ? shreg_q : data_q;
                    flag_d  = vote;
                    ferr_d  = !vote;
                end
            end
            WAIT_HI: state_d = rx_s ? IDLE : WAIT_HI;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 15'd0;
            d_q       <= 15'd0;
            h_q       <= 15'd0;
            bit_q     <= 4'd0;
            shreg_q   <= 8'd0;
            smp_q     <= 2'b11;
            data_q    <= 8'd0;
            flag_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_rx};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            h_q       <= h_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            smp_q     <= smp_d;
            data_q    <= data_d;
            flag_q    <= flag_d;
            ferr_q    <= ferr_d;
        end
    end
    assign o_data      = data_q;
    assign o_flag      = flag_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = state_q != IDLE;
endmodule
